// File: rtl/uart_tx_fifo.sv
// Buffered RS232 transmitter: byte FIFO feeding a 5-8 data bit serialiser with
// optional parity, 1/2 stop bits and a runtime baud divisor.
module uart_tx_fifo #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr,
    input  logic [7:0]       data,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       cfg_bits,
    input  logic [1:0]       cfg_par,
    input  logic             cfg_stop,
    output logic             rdy,
    output logic             empty,
    output logic             busy,
    output logic [LVL_W-1:0] level,
    output logic             ovf,
    output logic             TxD
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] timer, timer_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [2:0]       bitcnt, bitcnt_n;
    logic [7:0]       shreg, shreg_n;
    logic             par_acc, par_acc_n;
    logic [1:0]       bits_q, bits_n;
    logic [1:0]       par_q, par_n;
    logic             stop_q, stop_n;
    logic             stopcnt, stopcnt_n;
    logic             pop;
    logic             push;
    logic             endtick;
    logic             par_en;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;

    assign rdy     = (level != LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign busy    = (state != IDLE) | ~empty;
    assign push    = wr & enable & rdy;
    assign endtick = (timer == div_q);
    assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data;
        end
    end

    // ovf is registered: it pulses in the cycle after the rejected write
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= wr & enable & ~rdy;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            div_q   <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            bits_q  <= '0;
            par_q   <= '0;
            stop_q  <= 1'b0;
            stopcnt <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            div_q   <= div_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_acc <= par_acc_n;
            bits_q  <= bits_n;
            par_q   <= par_n;
            stop_q  <= stop_n;
            stopcnt <= stopcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        div_n     = div_q;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_acc_n = par_acc;
        bits_n    = bits_q;
        par_n     = par_q;
        stop_n    = stop_q;
        stopcnt_n = stopcnt;
        pop       = 1'b0;

        if (enable) begin
            timer_n = endtick ? '0 : timer + DIV_W'(1);
            case (state)
                IDLE: begin
                    timer_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rptr];
                        bits_n  = cfg_bits;
                        par_n   = cfg_par;
                        stop_n  = cfg_stop;
                        div_n   = divisor;
                        state_n = START;
                    end
                end
                START: begin
                    if (endtick) begin
                        state_n   = DATA;
                        bitcnt_n  = '0;
                        par_acc_n = 1'b0;
                    end
                end
                DATA: begin
                    if (endtick) begin
                        par_acc_n = par_acc ^ shreg[0];
                        shreg_n   = shreg >> 1;
                        if (bitcnt == ({1'b0, bits_q} + 3'd4)) begin
                            state_n   = par_en ? PARITY : STOP;
                            stopcnt_n = 1'b0;
                        end else begin
                            bitcnt_n = bitcnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (endtick) begin
                        state_n   = STOP;
                        stopcnt_n = 1'b0;
                    end
                end
                STOP: begin
                    if (endtick) begin
                        if (stopcnt == stop_q) begin
                            // back-to-back: reload straight into START, no idle bit
                            if (!empty) begin
                                pop     = 1'b1;
                                shreg_n = mem[rptr];
                                bits_n  = cfg_bits;
                                par_n   = cfg_par;
                                stop_n  = cfg_stop;
                                div_n   = divisor;
                                state_n = START;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            stopcnt_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        TxD = 1'b1;
        case (state)
            START:   TxD = 1'b0;
            DATA:    TxD = shreg[0];
            PARITY:  TxD = par_acc ^ (par_q == 2'b10);
            default: TxD = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a table of single frames with hand-derived
// bit strings, plus sequences for config change, overflow, reset and enable.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [7:0]  data;
    logic [15:0] divisor;
    logic [1:0]  cfg_bits;
    logic [1:0]  cfg_par;
    logic        cfg_stop;
    logic        rdy;
    logic        empty;
    logic        busy;
    logic [4:0]  level;
    logic        ovf;
    logic        TxD;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(16), .LVL_W(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .data(data),
        .divisor(divisor), .cfg_bits(cfg_bits), .cfg_par(cfg_par),
        .cfg_stop(cfg_stop), .rdy(rdy), .empty(empty), .busy(busy),
        .level(level), .ovf(ovf), .TxD(TxD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  bits;
        logic [1:0]  par;
        logic        stop;
        int unsigned div;
        string       exp;
    } vec_t;

    vec_t vq[$];

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                           input logic s, input int unsigned dv, input string e);
        vec_t v;
        v.d = d; v.bits = b; v.par = p; v.stop = s; v.div = dv; v.exp = e;
        vq.push_back(v);
    endtask

    // Starting from the negedge before the first start-bit cycle, every cycle of
    // each bit period must carry the expected level; one comparison per bit.
    task automatic check_bits(input string s, input int unsigned dv, input string name);
        for (int k = 0; k < s.len(); k++) begin
            logic expb;
            logic bad;
            logic got;
            expb = (s[k] == 8'h31);
            bad  = 1'b0;
            got  = expb;
            for (int unsigned c = 0; c <= dv; c++) begin
                tick(1);
                if (TxD !== expb) begin
                    bad = 1'b1;
                    got = TxD;
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit %0d: TxD got %b expected %b", name, k, got, expb);
            end
        end
    endtask

    function automatic string frame8n1(input logic [7:0] d);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) s = {s, d[i] ? "1" : "0"};
        s = {s, "1"};
        return s;
    endfunction

    initial begin
        rst = 1'b0; enable = 1'b1; wr = 1'b0; data = '0; divisor = 16'd3;
        cfg_bits = 2'd3; cfg_par = 2'd0; cfg_stop = 1'b0;

        add_vec(8'h55, 2'd3, 2'd0, 1'b0, 1301, "0101010101");
        add_vec(8'h41, 2'd2, 2'd1, 1'b1, 5,    "01000001011");
        add_vec(8'hA3, 2'd0, 2'd2, 1'b0, 0,    "01100011");
        add_vec(8'h3C, 2'd1, 2'd3, 1'b1, 2,    "000111111");
        add_vec(8'hFF, 2'd3, 2'd2, 1'b0, 1,    "01111111111");
        add_vec(8'h80, 2'd3, 2'd1, 1'b0, 3,    "00000000111");
        add_vec(8'hE0, 2'd0, 2'd1, 1'b0, 2,    "00000001");

        tick(3);
        chk("reset TxD", TxD, 1);
        chk("reset rdy", rdy, 1);
        chk("reset empty", empty, 1);
        chk("reset busy", busy, 0);
        chk("reset level", level, 0);
        chk("reset ovf", ovf, 0);
        rst = 1'b1;
        tick(1);

        foreach (vq[i]) begin
            divisor  = 16'(vq[i].div);
            cfg_bits = vq[i].bits;
            cfg_par  = vq[i].par;
            cfg_stop = vq[i].stop;
            data     = vq[i].d;
            wr       = 1'b1;
            tick(1);
            wr = 1'b0;
            chk($sformatf("vec%0d latency TxD", i), TxD, 1);
            chk($sformatf("vec%0d busy queued", i), busy, 1);
            check_bits(vq[i].exp, vq[i].div, $sformatf("vec%0d", i));
            tick(1);
            chk($sformatf("vec%0d idle TxD", i), TxD, 1);
            chk($sformatf("vec%0d idle busy", i), busy, 0);
        end

        // config and divisor change mid-frame only affect the following frame
        divisor = 16'd2; cfg_bits = 2'd3; cfg_par = 2'd0; cfg_stop = 1'b0;
        data = 8'h0F; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        fork
            check_bits("0111100001", 2, "cfgchg f1");
            begin
                tick(2);
                cfg_par = 2'd1; cfg_stop = 1'b1; divisor = 16'd1;
                data = 8'h0F; wr = 1'b1;
                tick(1);
                wr = 1'b0;
            end
        join
        check_bits("011110000011", 1, "cfgchg f2");
        tick(1);
        chk("cfgchg idle busy", busy, 0);

        // fill while busy: 16 accepted, 17th dropped with ovf, then 16 frames back-to-back
        divisor = 16'd3; cfg_bits = 2'd3; cfg_par = 2'd0; cfg_stop = 1'b0;
        data = 8'hC3; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        tick(1);
        for (int i = 0; i < 17; i++) begin
            data = 8'h30 + 8'(i);
            wr   = 1'b1;
            if (i == 16) begin
                chk("full level", level, 16);
                chk("full rdy", rdy, 0);
                chk("ovf before", ovf, 0);
            end
            tick(1);
        end
        wr = 1'b0;
        chk("ovf pulse", ovf, 1);
        chk("level after drop", level, 16);
        tick(1);
        chk("ovf one cycle", ovf, 0);
        tick(21);
        chk("frame0 stop", TxD, 1);
        for (int j = 0; j < 16; j++) begin
            check_bits(frame8n1(8'h30 + 8'(j)), 3, $sformatf("b2b frame%0d", j + 1));
        end
        tick(1);
        chk("b2b busy drop", busy, 0);
        chk("b2b level", level, 0);
        chk("b2b TxD idle", TxD, 1);

        // reset mid data bit of frame 2 of 4
        data = 8'hA5; wr = 1'b1; tick(1);
        data = 8'h00; tick(1);
        data = 8'hFF; tick(1);
        data = 8'h0F; tick(1);
        wr = 1'b0;
        tick(43);
        chk("f2 data bit0", TxD, 0);
        chk("f2 level", level, 2);
        rst = 1'b0;
        tick(1);
        chk("abort TxD", TxD, 1);
        chk("abort level", level, 0);
        chk("abort busy", busy, 0);
        chk("abort empty", empty, 1);
        chk("abort rdy", rdy, 1);
        rst = 1'b1;
        begin
            logic stayed;
            stayed = 1'b1;
            for (int i = 0; i < 120; i++) begin
                tick(1);
                if (TxD !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
            end
            chk("no restart", stayed, 1);
        end

        // enable low for 500 cycles inside the start bit stretches it
        divisor = 16'd1301; cfg_bits = 2'd3; cfg_par = 2'd0; cfg_stop = 1'b0;
        data = 8'h55; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        begin
            int n;
            n = 0;
            tick(1);
            while (TxD === 1'b0 && n < 5000) begin
                n++;
                if (n == 300) begin
                    enable = 1'b0;
                    data   = 8'h12;
                    wr     = 1'b1;
                end
                if (n == 800) begin
                    chk("frozen level", level, 0);
                    enable = 1'b1;
                    wr     = 1'b0;
                end
                tick(1);
            end
            chk("stretched start bit", n, 1802);
        end
        enable = 1'b0;
        rst    = 1'b0;
        tick(1);
        chk("reset over enable TxD", TxD, 1);
        chk("reset over enable busy", busy, 0);
        rst    = 1'b1;
        enable = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
